// File: rtl/fnd_scan_drv.sv
// Time-multiplexed N-digit 7-segment (FND) scan driver.
// Scans one digit per slot of SCAN_DIV clocks. The segment lines are shared by all digits,
// and each digit has its own common enable. The driver also provides leading-zero blanking,
// a decimal point per digit, blinking per digit, and one dead cycle per slot against ghosting.
// All inputs are captured once per frame, so the display never shows a mix of two frames.
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   din_i         hex nibble per digit, din_i[4k+3:4k] = digit k (digit 0 = rightmost)
//   dp_i          decimal point request per digit
//   blank_lz_i    enable leading-zero blanking
//   blink_en_i    per-digit blink enable
//   seg_o         segments {g,f,e,d,c,b,a}
//   dp_o          decimal point segment
//   com_o         digit common enables (one active, or all inactive)
//   frame_tick_o  one-cycle pulse after each snapshot
module fnd_scan_drv #(
    parameter int unsigned N_DIGIT      = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter bit          SEG_ACT_LOW  = 1'b1,
    parameter bit          COM_ACT_LOW  = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [4*N_DIGIT-1:0]   din_i,
    input  logic [N_DIGIT-1:0]     dp_i,
    input  logic                   blank_lz_i,
    input  logic [N_DIGIT-1:0]     blink_en_i,
    output logic [6:0]             seg_o,
    output logic                   dp_o,
    output logic [N_DIGIT-1:0]     com_o,
    output logic                   frame_tick_o
);

    localparam int unsigned CntW   = $clog2(SCAN_DIV);
    localparam int unsigned IdxW   = (N_DIGIT > 1) ? $clog2(N_DIGIT) : 1;
    localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Glyph table in active-low form, bit0 = segment a.
    function automatic logic [6:0] glyph_al(input logic [3:0] nib);
        logic [6:0] g;
        unique case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h58;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h04;
            4'hF: g = 7'h0E;
        endcase
        return g;
    endfunction

    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [BlinkW-1:0]    blink_cnt_q, blink_cnt_d;
    logic                 blink_off_q, blink_off_d;
    logic [4*N_DIGIT-1:0] din_q, din_d;
    logic [N_DIGIT-1:0]   dp_req_q, dp_req_d;
    logic                 blz_q, blz_d;
    logic [N_DIGIT-1:0]   blink_q, blink_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic [N_DIGIT-1:0]   com_q, com_d;
    logic                 tick_q, tick_d;

    logic                 cap;
    logic [N_DIGIT:0]     zero_from;    // zero_from[k]: digits k..N_DIGIT-1 are all zero
    logic [N_DIGIT-1:0]   onehot;
    logic [3:0]           nib;
    logic                 lz_blank;
    logic                 dp_req;
    logic                 blink_req;
    logic                 blanked;
    logic [6:0]           seg_al;

    always_comb begin
        cap = (cnt_q == '0) && (idx_q == '0);

        // Slot and digit counters
        cnt_d = cnt_q + CntW'(1);
        idx_d = idx_q;
        if (cnt_q == CntW'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IdxW'(N_DIGIT - 1)) ? '0 : idx_q + IdxW'(1);
        end

        // The snapshot is loaded from the live inputs on the capture cycle. The capture cycle
        // uses the live values directly, so the whole frame shows one consistent snapshot.
        din_d    = cap ? din_i      : din_q;
        dp_req_d = cap ? dp_i       : dp_req_q;
        blz_d    = cap ? blank_lz_i : blz_q;
        blink_d  = cap ? blink_en_i : blink_q;

        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (cap) begin
            if (blink_cnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BlinkW'(1);
            end
        end

        zero_from[N_DIGIT] = 1'b1;
        for (int k = N_DIGIT - 1; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] && (din_d[4*k +: 4] == 4'h0);
        end

        onehot    = '0;
        nib       = 4'h0;
        lz_blank  = 1'b0;
        dp_req    = 1'b0;
        blink_req = 1'b0;
        for (int k = 0; k < N_DIGIT; k++) begin
            if (idx_q == IdxW'(k)) begin
                onehot[k] = 1'b1;
                nib       = din_d[4*k +: 4];
                lz_blank  = blz_d && (k != 0) && zero_from[k];
                dp_req    = dp_req_d[k];
                blink_req = blink_d[k];
            end
        end

        blanked = lz_blank || (blink_req && blink_off_d);
        seg_al  = blanked ? 7'h7F : glyph_al(nib);
        seg_d   = SEG_ACT_LOW ? seg_al : ~seg_al;
        dp_d    = (dp_req && !blanked) ^ SEG_ACT_LOW;
        // Dead cycle at cnt 0: every common is off while the segments settle on the new digit.
        com_d   = (cnt_q == '0) ? '0 : onehot;
        if (COM_ACT_LOW) begin
            com_d = ~com_d;
        end
        tick_d  = cap;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
            din_q       <= '0;
            dp_req_q    <= '0;
            blz_q       <= 1'b0;
            blink_q     <= '0;
            seg_q       <= SEG_ACT_LOW ? 7'h7F : 7'h00;
            dp_q        <= SEG_ACT_LOW;
            com_q       <= COM_ACT_LOW ? '1 : '0;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
            din_q       <= din_d;
            dp_req_q    <= dp_req_d;
            blz_q       <= blz_d;
            blink_q     <= blink_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            com_q       <= com_d;
            tick_q      <= tick_d;
        end
    end

    assign seg_o        = seg_q;
    assign dp_o         = dp_q;
    assign com_o        = com_q;
    assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_fnd_scan_drv.sv
// Bench for fnd_scan_drv. It drives two instances from the same inputs: one with both polarities
// active-low and one with both active-high. A frame-level behavioural model is checked on every
// cycle, and a set of hand-computed literal checks pins the model itself.
module tb_fnd_scan_drv;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   din;
    logic [3:0]    dpv;
    logic          blz;
    logic [3:0]    ben;

    logic [6:0]    seg_l, seg_h;
    logic          dp_l, dp_h;
    logic [3:0]    com_l, com_h;
    logic          tick_l, tick_h;

    int checks = 0;
    int errors = 0;
    int n      = 0;   // negedges since last reset release

    always #5 clk = ~clk;

    fnd_scan_drv #(
        .N_DIGIT(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .SEG_ACT_LOW(1'b1), .COM_ACT_LOW(1'b1)
    ) u_dut_al (
        .clk_i(clk), .rst_i(rst), .din_i(din), .dp_i(dpv), .blank_lz_i(blz), .blink_en_i(ben),
        .seg_o(seg_l), .dp_o(dp_l), .com_o(com_l), .frame_tick_o(tick_l)
    );

    fnd_scan_drv #(
        .N_DIGIT(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .SEG_ACT_LOW(1'b0), .COM_ACT_LOW(1'b0)
    ) u_dut_ah (
        .clk_i(clk), .rst_i(rst), .din_i(din), .dp_i(dpv), .blank_lz_i(blz), .blink_en_i(ben),
        .seg_o(seg_h), .dp_o(dp_h), .com_o(com_h), .frame_tick_o(tick_h)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (active-low view) ----------------
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h04, 7'h0E};
    bit          valid = 1'b0;
    int          cyc;
    logic [15:0] s_din;
    logic [3:0]  s_dp, s_be;
    logic        s_blz;
    logic [6:0]  e_seg;
    logic        e_dp, e_tick;
    logic [3:0]  e_com;

    always @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b1;
            cyc    <= 0;
            s_din  <= '0;
            s_dp   <= '0;
            s_be   <= '0;
            s_blz  <= 1'b0;
            e_seg  <= 7'h7F;
            e_dp   <= 1'b1;
            e_com  <= 4'hF;
            e_tick <= 1'b0;
        end else if (valid) begin : model
            automatic int          cnt  = cyc % SD;
            automatic int          slot = cyc / SD;
            automatic int          idx  = slot % ND;
            automatic int          f    = slot / ND;
            automatic bit          cap  = (cnt == 0) && (idx == 0);
            automatic logic [15:0] d    = cap ? din : s_din;
            automatic logic [3:0]  p    = cap ? dpv : s_dp;
            automatic logic [3:0]  b    = cap ? ben : s_be;
            automatic logic        z    = cap ? blz : s_blz;
            // Frame f has seen f+1 captures; phase toggles once per BF captures.
            automatic bit          off  = (((f + 1) / BF) % 2) == 1;
            automatic logic [15:0] hi   = d >> (4 * idx);
            automatic bit          bl   = (z && idx > 0 && hi == 16'h0) || (b[idx] && off);
            s_din  <= d;
            s_dp   <= p;
            s_be   <= b;
            s_blz  <= z;
            e_seg  <= bl ? 7'h7F : glyph[hi[3:0]];
            e_dp   <= !(p[idx] && !bl);
            e_com  <= (cnt == 0) ? 4'hF : ~(4'b0001 << idx);
            e_tick <= cap;
            cyc    <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            chk("m_seg_al",  {9'd0, seg_l},  {9'd0, e_seg});
            chk("m_dp_al",   {15'd0, dp_l},  {15'd0, e_dp});
            chk("m_com_al",  {12'd0, com_l}, {12'd0, e_com});
            chk("m_tick_al", {15'd0, tick_l}, {15'd0, e_tick});
            chk("m_seg_ah",  {9'd0, seg_h},  {9'd0, ~e_seg});
            chk("m_dp_ah",   {15'd0, dp_h},  {15'd0, ~e_dp});
            chk("m_com_ah",  {12'd0, com_h}, {12'd0, ~e_com});
            chk("m_tick_ah", {15'd0, tick_h}, {15'd0, e_tick});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_to(input int k);
        while (n < k) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic restart(input logic [15:0] d, input logic [3:0] p, input logic z,
                           input logic [3:0] b);
        rst = 1'b1;
        @(negedge clk);
        din = d; dpv = p; blz = z; ben = b;
        rst = 1'b0;
        n   = 0;
    endtask

    task automatic lit(input string name, input logic [6:0] s, input logic d, input logic [3:0] c);
        chk({name, "_seg"}, {9'd0, seg_l}, {9'd0, s});
        chk({name, "_dp"},  {15'd0, dp_l}, {15'd0, d});
        chk({name, "_com"}, {12'd0, com_l}, {12'd0, c});
    endtask

    initial begin
        rst = 1'b1; din = 16'h1234; dpv = '0; blz = 1'b0; ben = '0;

        // T1 reset held three cycles
        repeat (3) @(negedge clk);
        lit("t1_rst", 7'h7F, 1'b1, 4'hF);
        chk("t1_tick", {15'd0, tick_l}, 16'd0);
        chk("t1_seg_ah", {9'd0, seg_h}, 16'h00);
        chk("t1_com_ah", {12'd0, com_h}, 16'h0);
        rst = 1'b0;
        n   = 0;

        // T2 scan of 1234
        run_to(1);  chk("t2_tick1", {15'd0, tick_l}, 16'd1); lit("t2_d0dead", 7'h19, 1'b1, 4'hF);
        run_to(2);  chk("t2_tick2", {15'd0, tick_l}, 16'd0); lit("t2_d0", 7'h19, 1'b1, 4'hE);
        run_to(5);  lit("t2_d1dead", 7'h30, 1'b1, 4'hF);
        run_to(6);  lit("t2_d1", 7'h30, 1'b1, 4'hD);
        run_to(10); lit("t2_d2", 7'h24, 1'b1, 4'hB);
        run_to(14); lit("t2_d3", 7'h79, 1'b1, 4'h7);
        run_to(16); chk("t2_tick16", {15'd0, tick_l}, 16'd0);
        run_to(17); chk("t2_tick17", {15'd0, tick_l}, 16'd1);

        // T3 leading-zero blanking
        restart(16'h0050, 4'hF, 1'b1, 4'h0);
        run_to(2);  lit("t3_d0", 7'h40, 1'b0, 4'hE);
        run_to(6);  lit("t3_d1", 7'h12, 1'b0, 4'hD);
        run_to(10); lit("t3_d2", 7'h7F, 1'b1, 4'hB);
        run_to(11); blz = 1'b0;
        run_to(14); lit("t3_d3", 7'h7F, 1'b1, 4'h7);
        run_to(18); lit("t3_nb_d0", 7'h40, 1'b0, 4'hE);
        run_to(22); lit("t3_nb_d1", 7'h12, 1'b0, 4'hD);
        run_to(26); lit("t3_nb_d2", 7'h40, 1'b0, 4'hB);
        run_to(30); lit("t3_nb_d3", 7'h40, 1'b0, 4'h7);

        // T4 no tearing
        restart(16'h1111, 4'h0, 1'b0, 4'h0);
        run_to(7);  din = 16'h2222;
        run_to(10); lit("t4_f0d2", 7'h79, 1'b1, 4'hB);
        run_to(14); lit("t4_f0d3", 7'h79, 1'b1, 4'h7);
        run_to(18); lit("t4_f1d0", 7'h24, 1'b1, 4'hE);

        // T5 blink on digit 0
        restart(16'h0000, 4'b0001, 1'b0, 4'b0001);
        run_to(2);  lit("t5_f0", 7'h40, 1'b0, 4'hE);
        run_to(18); lit("t5_f1", 7'h7F, 1'b1, 4'hE);
        run_to(22); lit("t5_f1d1", 7'h40, 1'b1, 4'hD);
        run_to(34); lit("t5_f2", 7'h7F, 1'b1, 4'hE);
        run_to(50); lit("t5_f3", 7'h40, 1'b0, 4'hE);
        run_to(66); lit("t5_f4", 7'h40, 1'b0, 4'hE);
        run_to(82); lit("t5_f5", 7'h7F, 1'b1, 4'hE);

        // T6 active-high instance, reset at cnt 2 of slot 2
        restart(16'h0008, 4'h0, 1'b0, 4'h0);
        run_to(2);
        chk("t6_seg_ah", {9'd0, seg_h}, 16'h7F);
        chk("t6_com_ah", {12'd0, com_h}, 16'h1);
        run_to(10);
        chk("t6_com_ah_s2", {12'd0, com_h}, 16'h4);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_seg_ah", {9'd0, seg_h}, 16'h00);
        chk("t6_rst_com_ah", {12'd0, com_h}, 16'h0);
        chk("t6_rst_dp_ah", {15'd0, dp_h}, 16'h0);
        rst = 1'b0;
        n   = 0;
        run_to(1);
        chk("t6_re_dead", {12'd0, com_h}, 16'h0);
        chk("t6_re_tick", {15'd0, tick_h}, 16'd1);
        run_to(2);
        chk("t6_re_seg", {9'd0, seg_h}, 16'h7F);
        chk("t6_re_com", {12'd0, com_h}, 16'h1);

        run_to(8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
